// File: rtl/stack_pkg.sv
// Shared types and defaults for the stacker row engine.
// FSM state codes, direction codes and default geometry.
package stack_pkg;

  localparam int         DEF_WIDTH     = 8;
  localparam int         DEF_ROWS      = 8;
  localparam logic [7:0] DEF_START_PAT = 8'b0000_0111;
  localparam int         ROW_W         = 3;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_LOCK  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/stack_row_shifter.sv
// Combinational one-step shift of the moving block with edge bounce.
// Ports: cur/dir in, nxt_cur/nxt_dir out; a full row never moves.
module stack_row_shifter
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt_cur,
  output logic             nxt_dir
);

  logic full;
  logic top;
  logic bot;
  logic lft;

  assign full = &cur;
  assign top  = cur[WIDTH-1];
  assign bot  = cur[0];
  assign lft  = (dir == DIR_LEFT);

  always_comb begin
    nxt_cur = cur;
    nxt_dir = dir;
    unique case (1'b1)
      full: begin
        nxt_cur = cur;
      end
      (!full && lft && top): begin
        nxt_dir = DIR_RIGHT;
        nxt_cur = cur >> 1;
      end
      (!full && lft && !top): begin
        nxt_cur = cur << 1;
      end
      (!full && !lft && bot): begin
        nxt_dir = DIR_LEFT;
        nxt_cur = cur << 1;
      end
      (!full && !lft && !bot): begin
        nxt_cur = cur >> 1;
      end
    endcase
  end

endmodule

// File: rtl/stack_row_engine.sv
// Stacker game row engine: moves a block, locks rows, judges win/lose.
// Ports: clk, reset, btn, update_tick in; val, row_index, write_strobe, clr_array, state out.
module stack_row_engine
  import stack_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               ROWS      = DEF_ROWS,
  parameter logic [WIDTH-1:0] START_PAT = WIDTH'(DEF_START_PAT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             update_tick,
  output logic [WIDTH-1:0] val,
  output logic [2:0]       row_index,
  output logic             write_strobe,
  output logic             clr_array,
  output logic [2:0]       state
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] lock_q, lock_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [2:0]       row_q, row_d;
  logic             dir_q, dir_d;
  logic             ws_q, ws_d;

  logic [WIDTH-1:0] sh_cur;
  logic             sh_dir;

  stack_row_shifter #(
    .WIDTH (WIDTH)
  ) u_shift (
    .cur     (cur_q),
    .dir     (dir_q),
    .nxt_cur (sh_cur),
    .nxt_dir (sh_dir)
  );

  // Strobes are registered on the transition so they land
  // in the first cycle of the state they announce.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    lock_d  = lock_q;
    val_d   = val_q;
    row_d   = row_q;
    dir_d   = dir_q;
    ws_d    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        cur_d   = START_PAT;
        prev_d  = '1;
        dir_d   = DIR_LEFT;
        row_d   = '0;
        val_d   = START_PAT;
        ws_d    = 1'b1;
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (btn) begin
          lock_d  = cur_q & prev_q;
          val_d   = cur_q & prev_q;
          ws_d    = 1'b1;
          state_d = ST_LOCK;
        end else if (update_tick) begin
          cur_d = sh_cur;
          dir_d = sh_dir;
          if (sh_cur != cur_q) begin
            val_d = sh_cur;
            ws_d  = 1'b1;
          end
        end
      end
      ST_LOCK: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (lock_q == '0) begin
          state_d = ST_LOSE;
        end else if (row_q == 3'(ROWS - 1)) begin
          state_d = ST_WIN;
        end else begin
          prev_d  = lock_q;
          cur_d   = lock_q;
          val_d   = lock_q;
          row_d   = row_q + 3'd1;
          ws_d    = 1'b1;
          state_d = ST_MOVE;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (btn) begin
          state_d = ST_INIT;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cur_q   <= '0;
      prev_q  <= '1;
      lock_q  <= '0;
      val_q   <= '0;
      row_q   <= '0;
      dir_q   <= DIR_LEFT;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      lock_q  <= lock_d;
      val_q   <= val_d;
      row_q   <= row_d;
      dir_q   <= dir_d;
      ws_q    <= ws_d;
    end
  end

  // Clear is tied to the INIT state itself; reset gates it so the
  // pulse appears only in the cycle after reset releases.
  assign clr_array    = (state_q == ST_INIT) && !reset;
  assign write_strobe = ws_q;
  assign val          = val_q;
  assign row_index    = row_q;
  assign state        = state_q;

endmodule

// File: tb/tb_stack_row_engine.sv
// Self-checking bench for stack_row_engine.
// Block tracked as (position, length) interval; rows locked by overlap.
module tb_stack_row_engine;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         btn;
  logic         update_tick;
  logic [W-1:0] val;
  logic [2:0]   row_index;
  logic         write_strobe;
  logic         clr_array;
  logic [2:0]   state;

  int checks;
  int failures;
  int n_ws;

  int m_pos, m_len, m_dir;
  int p_pos, p_len;

  stack_row_engine dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .update_tick  (update_tick),
    .val          (val),
    .row_index    (row_index),
    .write_strobe (write_strobe),
    .clr_array    (clr_array),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_strobe) n_ws++;
    if (write_strobe || clr_array) begin
      checks++;
      if (write_strobe && clr_array) begin
        failures++;
        $display("FAIL ws_clr_overlap got=both want=one");
      end
      checks++;
      if (row_index > 3'd7) begin
        failures++;
        $display("FAIL row_range got=%0d want<=7", row_index);
      end
    end
  end

  function automatic logic [W-1:0] pat(int pos, int len);
    logic [15:0] v;
    v = ((16'd1 << len) - 16'd1) << pos;
    return v[W-1:0];
  endfunction

  task automatic cycle(input logic b, input logic t);
    btn = b;
    update_tick = t;
    @(posedge clk);
    #1;
    btn = 1'b0;
    update_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(0, 0);
    cycle(0, 0);
    reset = 1'b0;
    cycle(0, 0);
    m_pos = 0; m_len = 3; m_dir = 0;
    p_pos = 0; p_len = W;
  endtask

  // dir 0 = left (toward MSB), 1 = right
  task automatic model_tick(output bit ch);
    ch = 1'b1;
    if (m_len == W) ch = 1'b0;
    else if (m_dir == 0) begin
      if (m_pos + m_len == W) begin m_dir = 1; m_pos--; end
      else m_pos++;
    end else begin
      if (m_pos == 0) begin m_dir = 0; m_pos++; end
      else m_pos--;
    end
  endtask

  task automatic model_lock();
    int lo, hi;
    lo = (m_pos > p_pos) ? m_pos : p_pos;
    hi = (m_pos + m_len < p_pos + p_len) ? m_pos + m_len : p_pos + p_len;
    if (hi > lo) begin m_pos = lo; m_len = hi - lo; end
    else m_len = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(1, 1);
    cycle(0, 1);
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d want=0", state); end
    checks++;
    if (val !== 8'h00) begin failures++; $display("FAIL rst_val got=%h want=00", val); end
    checks++;
    if (row_index !== 3'd0) begin failures++; $display("FAIL rst_row got=%0d want=0", row_index); end
    checks++;
    if (write_strobe !== 1'b0 || clr_array !== 1'b0) begin
      failures++; $display("FAIL rst_pulses got=%b%b want=00", write_strobe, clr_array);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (clr_array !== 1'b1 || state !== 3'd0) begin
      failures++; $display("FAIL init_cycle got=clr%b st%0d want=clr1 st0", clr_array, state);
    end
    cycle(0, 0);
    checks++;
    if (state !== 3'd1 || write_strobe !== 1'b1 || val !== 8'h07 || row_index !== 3'd0) begin
      failures++;
      $display("FAIL first_move got=st%0d ws%b v%h r%0d want=st1 ws1 v07 r0",
               state, write_strobe, val, row_index);
    end
    checks++;
    if (clr_array !== 1'b0) begin failures++; $display("FAIL clr_once got=%b want=0", clr_array); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] exp [7];
    exp = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1);
      checks++;
      if (write_strobe !== 1'b1 || val !== exp[i]) begin
        failures++;
        $display("FAIL sweep%0d got=ws%b v%h want=ws1 v%h", i, write_strobe, val, exp[i]);
      end
      cycle(0, 0);
      checks++;
      if (write_strobe !== 1'b0 || val !== exp[i]) begin
        failures++;
        $display("FAIL sweep_hold%0d got=ws%b v%h want=ws0 v%h", i, write_strobe, val, exp[i]);
      end
    end
  endtask

  task automatic test_lock_overlap();
    do_reset();
    cycle(0, 1);
    cycle(0, 1);
    cycle(1, 0);
    cycle(0, 0);
    cycle(0, 0);
    cycle(0, 1);
    checks++;
    if (val !== 8'h38) begin failures++; $display("FAIL ov_pre got=%h want=38", val); end
    cycle(1, 0);
    checks++;
    if (state !== 3'd2 || write_strobe !== 1'b1 || val !== 8'h18 || row_index !== 3'd1) begin
      failures++;
      $display("FAIL ov_lock got=st%0d ws%b v%h r%0d want=st2 ws1 v18 r1",
               state, write_strobe, val, row_index);
    end
    cycle(0, 0);
    cycle(0, 0);
    checks++;
    if (state !== 3'd1 || val !== 8'h18 || row_index !== 3'd2 || write_strobe !== 1'b1) begin
      failures++;
      $display("FAIL ov_row2 got=st%0d ws%b v%h r%0d want=st1 ws1 v18 r2",
               state, write_strobe, val, row_index);
    end
  endtask

  task automatic test_lose();
    int snap;
    do_reset();
    cycle(1, 0);
    cycle(0, 0);
    cycle(0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1);
    cycle(1, 0);
    checks++;
    if (write_strobe !== 1'b1 || val !== 8'h00 || row_index !== 3'd1) begin
      failures++;
      $display("FAIL lose_write got=ws%b v%h r%0d want=ws1 v00 r1", write_strobe, val, row_index);
    end
    cycle(0, 0);
    cycle(0, 0);
    checks++;
    if (state !== 3'd5) begin failures++; $display("FAIL lose_state got=%0d want=5", state); end
    snap = n_ws;
    for (int i = 0; i < 5; i++) cycle(0, 1'($urandom_range(0, 1)));
    checks++;
    if (n_ws !== snap || state !== 3'd5 || val !== 8'h00) begin
      failures++;
      $display("FAIL lose_quiet got=ws%0d st%0d v%h want=ws%0d st5 v00", n_ws, state, val, snap);
    end
  endtask

  task automatic test_win();
    do_reset();
    for (int r = 0; r < 8; r++) begin
      cycle(1, 0);
      checks++;
      if (val !== 8'h07 || row_index !== 3'(r) || write_strobe !== 1'b1) begin
        failures++;
        $display("FAIL win_lock%0d got=v%h r%0d ws%b want=v07 r%0d ws1",
                 r, val, row_index, write_strobe, r);
      end
      cycle(1, 1);
      cycle(1, 0);
    end
    checks++;
    if (state !== 3'd4 || write_strobe !== 1'b0) begin
      failures++; $display("FAIL win_state got=st%0d ws%b want=st4 ws0", state, write_strobe);
    end
    cycle(0, 1);
    checks++;
    if (state !== 3'd4 || val !== 8'h07 || row_index !== 3'd7 || write_strobe !== 1'b0) begin
      failures++;
      $display("FAIL win_hold got=st%0d v%h r%0d ws%b want=st4 v07 r7 ws0",
               state, val, row_index, write_strobe);
    end
    cycle(1, 0);
    checks++;
    if (state !== 3'd0 || clr_array !== 1'b1) begin
      failures++; $display("FAIL win_restart got=st%0d clr%b want=st0 clr1", state, clr_array);
    end
    cycle(0, 0);
    checks++;
    if (state !== 3'd1 || row_index !== 3'd0 || val !== 8'h07 || write_strobe !== 1'b1) begin
      failures++;
      $display("FAIL win_newgame got=st%0d r%0d v%h ws%b want=st1 r0 v07 ws1",
               state, row_index, val, write_strobe);
    end
  endtask

  task automatic test_btn_tick();
    do_reset();
    cycle(0, 1);
    cycle(1, 1);
    checks++;
    if (state !== 3'd2 || val !== 8'h0E) begin
      failures++; $display("FAIL btn_prio got=st%0d v%h want=st2 v0E", state, val);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cycle(0, 1);
    cycle(1, 0);
    reset = 1'b1;
    cycle(1, 1);
    checks++;
    if (state !== 3'd0 || val !== 8'h00 || row_index !== 3'd0 ||
        write_strobe !== 1'b0 || clr_array !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=st%0d v%h r%0d ws%b clr%b want=st0 v00 r0 ws0 clr0",
               state, val, row_index, write_strobe, clr_array);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (clr_array !== 1'b1) begin failures++; $display("FAIL mid_init got=%b want=1", clr_array); end
    cycle(0, 0);
    checks++;
    if (state !== 3'd1 || val !== 8'h07) begin
      failures++; $display("FAIL mid_move got=st%0d v%h want=st1 v07", state, val);
    end
  endtask

  task automatic test_random_games();
    int ticks;
    bit ch;
    logic [W-1:0] exp;
    for (int g = 0; g < 30; g++) begin
      do_reset();
      for (int r = 0; r < 8; r++) begin
        ticks = $urandom_range(0, 10);
        for (int k = 0; k < ticks; k++) begin
          if ($urandom_range(0, 2) == 0) begin
            cycle(0, 0);
            checks++;
            if (write_strobe !== 1'b0) begin
              failures++; $display("FAIL rnd_idle g%0d got=%b want=0", g, write_strobe);
            end
          end
          model_tick(ch);
          cycle(0, 1);
          checks++;
          if (write_strobe !== ch || (ch && val !== pat(m_pos, m_len))) begin
            failures++;
            $display("FAIL rnd_tick g%0d r%0d got=ws%b v%h want=ws%b v%h",
                     g, r, write_strobe, val, ch, pat(m_pos, m_len));
          end
        end
        model_lock();
        exp = pat(m_pos, m_len);
        cycle(1, 1'($urandom_range(0, 1)));
        checks++;
        if (state !== 3'd2 || write_strobe !== 1'b1 || val !== exp || row_index !== 3'(r)) begin
          failures++;
          $display("FAIL rnd_lock g%0d got=st%0d ws%b v%h r%0d want=st2 ws1 v%h r%0d",
                   g, state, write_strobe, val, row_index, exp, r);
        end
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++;
        if (state !== 3'd3 || write_strobe !== 1'b0) begin
          failures++;
          $display("FAIL rnd_check g%0d got=st%0d ws%b want=st3 ws0", g, state, write_strobe);
        end
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (m_len == 0) begin
          checks++;
          if (state !== 3'd5) begin
            failures++; $display("FAIL rnd_lose g%0d got=%0d want=5", g, state);
          end
          break;
        end else if (r == 7) begin
          checks++;
          if (state !== 3'd4) begin
            failures++; $display("FAIL rnd_win g%0d got=%0d want=4", g, state);
          end
        end else begin
          checks++;
          if (state !== 3'd1 || write_strobe !== 1'b1 || val !== exp ||
              row_index !== 3'(r + 1)) begin
            failures++;
            $display("FAIL rnd_next g%0d got=st%0d ws%b v%h r%0d want=st1 ws1 v%h r%0d",
                     g, state, write_strobe, val, row_index, exp, r + 1);
          end
          p_pos = m_pos;
          p_len = m_len;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    n_ws = 0;
    reset = 1'b1;
    btn = 1'b0;
    update_tick = 1'b0;
    test_reset();
    test_sweep();
    test_lock_overlap();
    test_lose();
    test_win();
    test_btn_tick();
    test_mid_reset();
    test_random_games();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_row_engine.md
STACK_ROW_ENGINE -- requirements
Module: stack_row_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, columns per row (bits in val).
REQ-002 SHALL have parameter ROWS, default 8, rows per game.
REQ-003 SHALL have parameter START_PAT, default 8'b0000_0111, initial moving-block pattern.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port btn, input, 1, single-cycle debounced button pulse.
REQ-007 SHALL have port update_tick, input, 1, single-cycle movement-rate pulse.
REQ-008 SHALL have port val, output, WIDTH, row pattern to store in the display array.
REQ-009 SHALL have port row_index, output, 3, current row, 0 = bottom.
REQ-010 SHALL have port write_strobe, output, 1, one-cycle pulse meaning val is valid for row_index.
REQ-011 SHALL have port clr_array, output, 1, one-cycle pulse meaning clear the whole display array.
REQ-012 SHALL have port state, output, 3, current FSM state encoding.

Function
REQ-013 SHALL implement states INIT=0, MOVE=1, LOCK=2, CHECK=3, WIN=4, LOSE=5, all registered.
REQ-014 In INIT, SHALL do the following for exactly one cycle, then enter MOVE: assert clr_array; load cur=START_PAT, prev=all-ones, dir=left and row_index=0.
REQ-015 On the first MOVE cycle after INIT or CHECK, SHALL pulse write_strobe with val=cur.
REQ-016 In MOVE, update_tick without btn SHALL shift cur one bit in dir.
REQ-017 Bounce rule, direction left: if cur[WIDTH-1]=1, SHALL set dir=right and shift right instead.
REQ-018 Bounce rule, direction right: if cur[0]=1, SHALL set dir=left and shift left instead.
REQ-019 If cur is all-ones, update_tick SHALL leave cur and dir unchanged.
REQ-020 After each cur change, SHALL pulse write_strobe in the next cycle with val=new cur; one write per change.
REQ-021 In MOVE, btn SHALL enter LOCK; btn has priority over a simultaneous update_tick, which is discarded with no shift.
REQ-022 In LOCK (one cycle), SHALL compute locked=cur AND prev, pulse write_strobe with val=locked at the current row_index, then enter CHECK.
REQ-023 In CHECK (one cycle), SHALL enter LOSE if locked=0.
REQ-024 In CHECK, if locked is nonzero and row_index=ROWS-1, SHALL enter WIN.
REQ-025 In CHECK otherwise, SHALL set prev=locked, cur=locked, row_index+1, keep dir, then enter MOVE.
REQ-026 WIN and LOSE SHALL hold all outputs stable with write_strobe=0; btn SHALL enter INIT; update_tick SHALL be ignored.
REQ-027 btn SHALL be ignored in LOCK, CHECK and INIT.
REQ-028 write_strobe and clr_array SHALL never be asserted in the same cycle.
REQ-029 row_index SHALL never exceed ROWS-1 and SHALL never wrap.
REQ-030 val SHALL hold its last written value between strobes.

Reset
REQ-031 Reset SHALL force state=INIT, val=0, row_index=0, write_strobe=0, clr_array=0, cur=0, prev=all-ones, dir=left.
REQ-032 Reset asserted mid-game, in any state, SHALL abort the game; INIT SHALL run in the first cycle after reset deasserts.
REQ-033 Reset SHALL take priority over btn and update_tick.

Structure
REQ-034 A shared package stack_pkg SHALL hold the state encodings, default WIDTH/ROWS/START_PAT and the dir encoding (left=0, right=1).
REQ-035 One sub-module, stack_row_shifter, SHALL be used: combinational; takes cur and dir; returns next cur and next dir per REQ-016..REQ-019.

Verification
REQ-036 Reset, then idle -> cycle 1: clr_array=1, state=INIT; cycle 2: state=MOVE, write_strobe=1, val=8'h07, row_index=0.
REQ-037 Five update_ticks from 8'h07 -> vals 0E,1C,38,70,E0. Next tick -> val=70 (bounce), dir=right.
REQ-038 Lock row 0 at 8'h1C; at row 1, tick to 8'h38 and press btn -> LOCK write val=8'h18, row_index=1; row 2 starts with cur=18.
REQ-039 Lock row 0 at 8'h07; at row 1, shift to 8'h70 and press btn -> locked=0, state=LOSE, write val=0 for row 1, then no further strobes.
REQ-040 Lock all 8 rows without shifting -> state=WIN after row 7; a later btn -> INIT with clr_array pulse.
REQ-041 btn and update_tick in the same MOVE cycle -> no shift; LOCK value equals the pre-tick cur.
